// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, flag bit positions and the
// operand bundle carried through the arbiter's execute stage.
// No ports; imported by the arbiter top and the testbench.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

    // Bit positions inside the {N,Z,C,V} flag nibble.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_ctrl_e         ctrl;
    } alu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   req       in   NREQ  request vector
//   ptr       in   IDW   index of the most recently granted requester
//   enable    in   1     grant allowed this cycle
//   grant     out  NREQ  one-hot grant, or zero
//   grant_idx out  IDW   encoded index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] idx;
    logic           found;

    // Scan ptr+1, ptr+2, ... ptr+NREQ (mod NREQ); the last-granted requester
    // is visited last, which bounds starvation to NREQ accepted transfers.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NREQ requesters.
// Round-robin grant, valid/ready on both sides, two pipeline stages:
// E holds the accepted operands (drives the ALU), R holds the ALU response.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot/zero)
//   req_a/req_b/req_ctrl    packed operands, requester i at [32*i+:32] / [2*i+:2]
//   rsp_valid/rsp_ready     per-requester response handshake (valid one-hot/zero)
//   rsp_result/rsp_flags    response data for the current R owner
//   alu_a/alu_b/alu_ctrl    to the ALU, driven from the E stage
//   alu_result/alu_flags    from the ALU
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ*2-1:0]   req_ctrl,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [31:0]         rsp_result,
    output logic [3:0]          rsp_flags,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [1:0]          alu_ctrl,
    input  logic [31:0]         alu_result,
    input  logic [3:0]          alu_flags
);

    logic            e_valid_q, e_valid_d;
    alu_op_t         e_op_q,    e_op_d;
    logic [IDW-1:0]  e_id_q,    e_id_d;
    logic            r_valid_q, r_valid_d;
    logic [31:0]     r_result_q, r_result_d;
    logic [3:0]      r_flags_q, r_flags_d;
    logic [IDW-1:0]  r_id_q,    r_id_d;
    logic [IDW-1:0]  rr_ptr_q,  rr_ptr_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            accept;
    logic            r_fire, r_free, e_free;
    alu_op_t         sel_op;

    assign r_fire = r_valid_q && rsp_ready[r_id_q];
    assign r_free = !r_valid_q || r_fire;
    assign e_free = !e_valid_q || r_free;

    // reset_n gates the grant so no requester sees ready while reset is held.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .enable    (e_free && reset_n),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op.a    = req_a[32*i +: 32];
                sel_op.b    = req_b[32*i +: 32];
                sel_op.ctrl = alu_ctrl_e'(req_ctrl[2*i +: 2]);
            end
        end
    end

    always_comb begin
        e_valid_d  = e_valid_q;
        e_op_d     = e_op_q;
        e_id_d     = e_id_q;
        r_valid_d  = r_valid_q;
        r_result_d = r_result_q;
        r_flags_d  = r_flags_q;
        r_id_d     = r_id_q;
        rr_ptr_d   = rr_ptr_q;

        if (accept) begin
            e_valid_d = 1'b1;
            e_op_d    = sel_op;
            e_id_d    = grant_idx;
            rr_ptr_d  = grant_idx;
        end else if (r_free) begin
            e_valid_d = 1'b0;
        end

        // E advances into R in the same cycle R drains, so a full pipe
        // sustains one op per cycle.
        if (e_valid_q && r_free) begin
            r_valid_d  = 1'b1;
            r_result_d = alu_result;
            r_flags_d  = alu_flags;
            r_id_d     = e_id_q;
        end else if (r_fire) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_valid_q  <= 1'b0;
            e_op_q     <= '0;
            e_id_q     <= '0;
            r_valid_q  <= 1'b0;
            r_result_q <= '0;
            r_flags_q  <= '0;
            r_id_q     <= '0;
            rr_ptr_q   <= IDW'(NREQ - 1);
        end else begin
            e_valid_q  <= e_valid_d;
            e_op_q     <= e_op_d;
            e_id_q     <= e_id_d;
            r_valid_q  <= r_valid_d;
            r_result_q <= r_result_d;
            r_flags_q  <= r_flags_d;
            r_id_q     <= r_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign alu_a    = e_op_q.a;
    assign alu_b    = e_op_q.b;
    assign alu_ctrl = e_op_q.ctrl;

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_valid_q && (r_id_q == IDW'(i));
        end
    end

    assign rsp_result = r_result_q;
    assign rsp_flags  = r_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with NREQ=2 and a behavioural ALU.
// Pending requests live in a queue; accepted ops push their expected response
// to a scoreboard that is popped in order when responses are handshaken.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctrl;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flags;
        int          cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a = '0;
    logic [NREQ*32-1:0]  req_b = '0;
    logic [NREQ*2-1:0]   req_ctrl = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '1;
    logic [31:0]         rsp_result;
    logic [3:0]          rsp_flags;
    logic [31:0]         alu_a, alu_b;
    logic [1:0]          alu_ctrl;
    logic [31:0]         alu_result;
    logic [3:0]          alu_flags;

    op_t   pend[$];
    exp_t  sb[$];
    int    grant_log[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_rsp    = 0;
    int    cyc      = 0;
    bit    strict_lat = 1'b0;
    logic [31:0] last_result;
    logic [3:0]  last_flags;
    int          last_id;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    // Returns {N,Z,C,V,result}; C on subtract is the not-borrow carry.
    function automatic logic [35:0] alu_model(logic [31:0] a, logic [31:0] b, logic [1:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cf, vf;
        s = '0; r = '0; cf = 1'b0; vf = 1'b0;
        case (c)
            ALU_ADD: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0]; cf = s[32];
                vf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0]; cf = s[32];
                vf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND: r = a & b;
            default: r = a | b;
        endcase
        return {r[31], (r == 32'd0), cf, vf, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

    function automatic int find_head(int id);
        for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == id) return k;
        end
        return -1;
    endfunction

    task automatic push_op(int id, logic [31:0] a, logic [31:0] b, logic [1:0] ctrl);
        op_t o;
        o.id = id; o.a = a; o.b = b; o.ctrl = ctrl;
        pend.push_back(o);
    endtask

    // Called at a negedge: drive, settle, observe handshakes, advance one cycle.
    task automatic step();
        exp_t              e;
        logic [35:0]       m;
        logic [NREQ-1:0]   exp_v;
        int                j;
        for (int i = 0; i < NREQ; i++) begin
            j = find_head(i);
            if (j >= 0) begin
                req_valid[i]        = 1'b1;
                req_a[32*i +: 32]   = pend[j].a;
                req_b[32*i +: 32]   = pend[j].b;
                req_ctrl[2*i +: 2]  = pend[j].ctrl;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        #1;
        n_checks++;
        if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) begin
            n_fail++;
            $display("FAIL req_ready_onehot: got req_ready=%b with req_valid=%b, required one-hot subset", req_ready, req_valid);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                j = find_head(i);
                m = alu_model(pend[j].a, pend[j].b, pend[j].ctrl);
                e.id = i; e.res = m[31:0]; e.flags = m[35:32]; e.cyc = cyc;
                sb.push_back(e);
                pend.delete(j);
                grant_log.push_back(i);
            end
        end
        if (rsp_valid != '0) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b, required no response", rsp_valid);
            end else begin
                e = sb[0];
                exp_v = '0;
                exp_v[e.id] = 1'b1;
                if (rsp_valid !== exp_v || rsp_result !== e.res || rsp_flags !== e.flags) begin
                    n_fail++;
                    $display("FAIL rsp_data: got valid=%b result=%h flags=%b, required valid=%b result=%h flags=%b",
                             rsp_valid, rsp_result, rsp_flags, exp_v, e.res, e.flags);
                end
                if (rsp_ready[e.id]) begin
                    last_result = rsp_result;
                    last_flags  = rsp_flags;
                    last_id     = e.id;
                    n_rsp++;
                    void'(sb.pop_front());
                    if (strict_lat) begin
                        n_checks++;
                        if (cyc - e.cyc != 2) begin
                            n_fail++;
                            $display("FAIL rsp_latency: got %0d cycles, required 2", cyc - e.cyc);
                        end
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(string name);
        int guard;
        guard = 0;
        while ((pend.size() != 0 || sb.size() != 0) && guard < 40) begin
            step();
            guard++;
        end
        n_checks++;
        if (pend.size() != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d unaccepted and %0d outstanding ops, required 0 and 0",
                     name, pend.size(), sb.size());
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b1;
        rsp_ready = '1;
        #2 reset_n = 1'b0;
        push_op(0, 32'd10, 32'd20, 2'(ALU_ADD));
        push_op(1, 32'd7, 32'd3, 2'(ALU_SUB));
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 00", req_ready); end
        n_checks++;
        if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 00", rsp_valid); end
        n_checks++;
        if (rsp_result !== 32'd0 || rsp_flags !== 4'd0) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h/%b, required 0/0", rsp_result, rsp_flags);
        end
        n_checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 2'b00) begin
            n_fail++; $display("FAIL reset_alu_ops: got %h %h %b, required zeros", alu_a, alu_b, alu_ctrl);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_checks++;
        if (grant_log.size() < 1 || grant_log[0] != 0) begin
            n_fail++; $display("FAIL reset_first_grant: got %0d entries, required first grant to requester 0", grant_log.size());
        end
        drain("reset");
    endtask

    task automatic test_single_add();
        push_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 2'(ALU_ADD));
        strict_lat = 1'b1;
        drain("single_add");
        strict_lat = 1'b0;
        n_checks++;
        if (last_result !== 32'h8000_0000 || last_flags !== 4'b1001 || last_id != 0) begin
            n_fail++;
            $display("FAIL single_add: got id=%0d result=%h flags=%b, required id=0 result=80000000 flags=1001",
                     last_id, last_result, last_flags);
        end
    endtask

    task automatic test_sub_and();
        push_op(1, 32'd5, 32'd5, 2'(ALU_SUB));
        drain("sub_zero");
        n_checks++;
        if (last_result !== 32'd0 || last_flags !== 4'b0110 || last_flags[FLAG_Z] !== 1'b1 || last_id != 1) begin
            n_fail++;
            $display("FAIL sub_zero: got id=%0d result=%h flags=%b, required id=1 result=0 flags=0110",
                     last_id, last_result, last_flags);
        end
        push_op(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'(ALU_AND));
        drain("and");
        n_checks++;
        if (last_result !== 32'h00F0_00F0 || last_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL and_op: got result=%h flags=%b, required result=00f000f0 flags=0000",
                     last_result, last_flags);
        end
    endtask

    task automatic test_round_robin();
        int base, rsp0;
        base = grant_log.size();
        rsp0 = n_rsp;
        for (int k = 0; k < 3; k++) begin
            push_op(0, $urandom, $urandom, 2'($urandom_range(0, 3)));
            push_op(1, $urandom, $urandom, 2'($urandom_range(0, 3)));
        end
        strict_lat = 1'b1;
        repeat (8) step();
        strict_lat = 1'b0;
        n_checks++;
        if (grant_log.size() < base + 6) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d grants, required 6", grant_log.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (grant_log[base + k] != k % 2) begin
                    n_fail++;
                    $display("FAIL rr_grant_%0d: got requester %0d, required %0d", k, grant_log[base + k], k % 2);
                end
            end
        end
        n_checks++;
        if (n_rsp - rsp0 != 6 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_throughput: got %0d responses in 8 cycles, required 6", n_rsp - rsp0);
        end
    endtask

    task automatic test_backpressure();
        int rsp0;
        rsp0 = n_rsp;
        rsp_ready[0] = 1'b0;
        push_op(0, 32'h0000_1000, 32'h0000_0001, 2'(ALU_ADD));
        push_op(0, 32'h0000_2000, 32'h0000_0002, 2'(ALU_SUB));
        push_op(0, 32'h0000_3000, 32'h0000_3003, 2'(ALU_ORR));
        repeat (5) step();
        n_checks++;
        if (sb.size() != 2 || pend.size() != 1) begin
            n_fail++;
            $display("FAIL bp_in_flight: got %0d in flight %0d waiting, required 2 and 1", sb.size(), pend.size());
        end
        n_checks++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL bp_req_ready: got %b, required 00", req_ready);
        end
        rsp_ready = '1;
        drain("backpressure");
        n_checks++;
        if (n_rsp - rsp0 != 3) begin
            n_fail++; $display("FAIL bp_count: got %0d responses, required 3", n_rsp - rsp0);
        end
    endtask

    task automatic test_reset_mid_op();
        int rsp0;
        rsp_ready = '0;
        push_op(0, 32'd100, 32'd1, 2'(ALU_ADD));
        push_op(0, 32'd200, 32'd2, 2'(ALU_ADD));
        repeat (3) step();
        n_checks++;
        if (rsp_valid !== 2'b01 || sb.size() != 2) begin
            n_fail++; $display("FAIL midrst_setup: got rsp_valid=%b outstanding=%0d, required 01 and 2", rsp_valid, sb.size());
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== '0 || req_ready !== '0 || rsp_result !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: got rsp_valid=%b req_ready=%b result=%h, required 00 00 0",
                     rsp_valid, req_ready, rsp_result);
        end
        pend.delete();
        sb.delete();
        req_valid = '0;
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = '1;
        rsp0      = n_rsp;
        repeat (5) step();
        n_checks++;
        if (n_rsp != rsp0) begin
            n_fail++; $display("FAIL midrst_stale: got %0d responses after release, required 0", n_rsp - rsp0);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_and();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
